// File: rtl/trace_event_checker.sv
`default_nettype none
// ============================================================================
// Module   : trace_event_checker
// Purpose  : Drains the trace sniff FIFO and checks every EVENT word against
//            a table of expected {rule, timestamp} pairs held in an external
//            expected-event RAM. TIME words reload the running timestamp
//            accumulator, STAT words are skipped, EVENT words add their short
//            delta to the accumulator and are compared. A per-event watchdog
//            ends the run if the FIFO stays empty for too long. Errors are
//            counted (saturating) and the first mismatch is captured.
// Revision : 1.0 - initial release
//
// Optional : TRACE_CHECKER_TOL_EN - adds time_tol_i; an event timestamp then
//            matches when |accumulator - expected| <= time_tol_i.
//
// Ports
//   usb_clk_i        sole clock (USB-side)
//   resetn_i         synchronous active-low reset
//   start_i          one-cycle pulse, begins a run (ignored while busy)
//   fifo_empty_i     sniff FIFO empty flag
//   fifo_rd_o        one-cycle FIFO pop
//   fifo_data_i      FIFO word, valid the cycle after fifo_rd_o
//   exp_addr_o       expected-table address
//   exp_data_i       {rule[63:56], time[55:0]}, valid a cycle after exp_addr_o
//   time_tol_i       timestamp tolerance (TRACE_CHECKER_TOL_EN only)
//   busy_o           run in progress
//   done_o           run finished, sticky until next start
//   pass_o           done with zero errors and no timeout
//   timeout_o        watchdog expired, sticky
//   error_count_o    saturating error count
//   event_count_o    events checked
//   first_err_idx_o  table index of first mismatch
//   first_err_got_o  {rule, time} received at first mismatch
// ============================================================================
module trace_event_checker #(
  parameter int pFIFO_W     = 32,
  parameter int pRULE_W     = 8,
  parameter int pSHORT_W    = 6,
  parameter int pTIME_W     = 32,
  parameter int pDEPTH_LOG2 = 8,
  parameter int pTIMEOUT    = 4096
) (
  input  logic                       usb_clk_i,
  input  logic                       resetn_i,
  input  logic                       start_i,
  input  logic                       fifo_empty_i,
  output logic                       fifo_rd_o,
  input  logic [pFIFO_W-1:0]         fifo_data_i,
  output logic [pDEPTH_LOG2-1:0]     exp_addr_o,
  input  logic [63:0]                exp_data_i,
`ifdef TRACE_CHECKER_TOL_EN
  input  logic [15:0]                time_tol_i,
`endif
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       timeout_o,
  output logic [15:0]                error_count_o,
  output logic [pDEPTH_LOG2:0]       event_count_o,
  output logic [pDEPTH_LOG2-1:0]     first_err_idx_o,
  output logic [pRULE_W+pTIME_W-1:0] first_err_got_o
);

  localparam int                   C_WD_W      = $clog2(pTIMEOUT + 1);
  localparam logic [C_WD_W-1:0]    C_WD_LAST   = C_WD_W'(pTIMEOUT - 1);
  localparam logic [pDEPTH_LOG2:0] C_TBL_FULL  = {1'b1, {pDEPTH_LOG2{1'b0}}};
  localparam logic [63:0]          C_SENTINEL  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [1:0]           C_CMD_EVENT = 2'b00;
  localparam logic [1:0]           C_CMD_TIME  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CHK_END = 3'd2,
    S_WAIT    = 3'd3,
    S_POP     = 3'd4,
    S_DECODE  = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  state_t                       state_q,    state_d;
  logic [pDEPTH_LOG2-1:0]       exp_addr_q, exp_addr_d;
  logic                         busy_q,     busy_d;
  logic                         done_q,     done_d;
  logic                         pass_q,     pass_d;
  logic                         timeout_q,  timeout_d;
  logic [15:0]                  err_cnt_q,  err_cnt_d;
  logic [pDEPTH_LOG2:0]         evt_cnt_q,  evt_cnt_d;
  logic [pDEPTH_LOG2-1:0]       fe_idx_q,   fe_idx_d;
  logic [pRULE_W+pTIME_W-1:0]   fe_got_q,   fe_got_d;
  logic                         fe_seen_q,  fe_seen_d;
  logic [pTIME_W-1:0]           acc_q,      acc_d;
  logic [C_WD_W-1:0]            wdog_q,     wdog_d;

  logic                         w_fifo_rd;

  // --------------------------------------------------------------------------
  // FIFO word fields
  // --------------------------------------------------------------------------
  logic [1:0]          w_cmd;
  logic [pRULE_W-1:0]  w_rule;
  logic [pSHORT_W-1:0] w_short;
  logic [pTIME_W-1:0]  w_full_time;
  logic [pTIME_W-1:0]  w_evt_acc;
  logic                w_rule_ok;
  logic                w_time_ok;
  logic [15:0]         w_err_inc;

  assign w_cmd       = fifo_data_i[1:0];
  assign w_rule      = fifo_data_i[8+pRULE_W-1:8];
  assign w_short     = fifo_data_i[2+pSHORT_W-1:2];
  // Shifting first then resizing takes bits [2+pTIME_W-1:2] and clips them
  // at the top of the FIFO word, zero-filling anything above.
  assign w_full_time = pTIME_W'(fifo_data_i >> 2);
  assign w_evt_acc   = acc_q + pTIME_W'(w_short);

  // Expected rule is an 8-bit field; a narrower rule must see zeros above it.
  assign w_rule_ok   = (exp_data_i[63:56] == 8'(w_rule));

`ifdef TRACE_CHECKER_TOL_EN
  localparam int C_CMP_W = (pTIME_W + 1 > 16) ? pTIME_W + 1 : 16;
  logic [pTIME_W:0] w_diff;
  logic [pTIME_W:0] w_mag;
  logic             w_exp_hi_zero;

  // Expected timestamps that do not fit in the accumulator can never match.
  assign w_exp_hi_zero = ((exp_data_i[55:0] >> pTIME_W) == 56'd0);
  assign w_diff        = {1'b0, w_evt_acc} - {1'b0, pTIME_W'(exp_data_i[55:0])};
  assign w_mag         = w_diff[pTIME_W] ? (~w_diff + 1'b1) : w_diff;
  assign w_time_ok     = w_exp_hi_zero &&
                         (C_CMP_W'(w_mag) <= C_CMP_W'(time_tol_i));
`else
  assign w_time_ok     = (56'(w_evt_acc) == exp_data_i[55:0]);
`endif

  assign w_err_inc = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    exp_addr_d = exp_addr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    err_cnt_d  = err_cnt_q;
    evt_cnt_d  = evt_cnt_q;
    fe_idx_d   = fe_idx_q;
    fe_got_d   = fe_got_q;
    fe_seen_d  = fe_seen_q;
    acc_d      = acc_q;
    wdog_d     = wdog_q;
    w_fifo_rd  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          exp_addr_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          err_cnt_d  = '0;
          evt_cnt_d  = '0;
          fe_idx_d   = '0;
          fe_got_d   = '0;
          fe_seen_d  = 1'b0;
          acc_d      = '0;
          wdog_d     = '0;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: state_d = S_CHK_END;

      S_CHK_END: begin
        if ((exp_data_i == C_SENTINEL) || (evt_cnt_q == C_TBL_FULL)) begin
          state_d = S_FINISH;
        end else begin
          // The accumulator carries across events: short fields are deltas
          // from the previous event, so only the watchdog restarts here.
          wdog_d  = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // Held at its last value so a pop on the final cycle cannot wrap it.
        wdog_d = (wdog_q == C_WD_LAST) ? wdog_q : wdog_q + 1'b1;
        if (!fifo_empty_i) begin
          // Gated by reset so an aborting cycle never pops a word.
          w_fifo_rd = resetn_i;
          state_d   = S_POP;
        end else if (wdog_q == C_WD_LAST) begin
          timeout_d = 1'b1;
          err_cnt_d = w_err_inc;
          state_d   = S_FINISH;
        end
      end

      S_POP: state_d = S_DECODE;

      S_DECODE: begin
        if (w_cmd == C_CMD_TIME) begin
          acc_d   = w_full_time;
          state_d = S_WAIT;
        end else if (w_cmd == C_CMD_EVENT) begin
          acc_d = w_evt_acc;
          if (!(w_rule_ok && w_time_ok)) begin
            err_cnt_d = w_err_inc;
            if (!fe_seen_q) begin
              fe_seen_d = 1'b1;
              fe_idx_d  = exp_addr_q;
              fe_got_d  = {w_rule, w_evt_acc};
            end
          end
          evt_cnt_d  = evt_cnt_q + 1'b1;
          exp_addr_d = exp_addr_q + 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_cnt_q == 16'd0) && !timeout_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge usb_clk_i) begin
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      exp_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_cnt_q  <= '0;
      evt_cnt_q  <= '0;
      fe_idx_q   <= '0;
      fe_got_q   <= '0;
      fe_seen_q  <= 1'b0;
      acc_q      <= '0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      exp_addr_q <= exp_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      err_cnt_q  <= err_cnt_d;
      evt_cnt_q  <= evt_cnt_d;
      fe_idx_q   <= fe_idx_d;
      fe_got_q   <= fe_got_d;
      fe_seen_q  <= fe_seen_d;
      acc_q      <= acc_d;
      wdog_q     <= wdog_d;
    end
  end

  assign fifo_rd_o       = w_fifo_rd;
  assign exp_addr_o      = exp_addr_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign timeout_o       = timeout_q;
  assign error_count_o   = err_cnt_q;
  assign event_count_o   = evt_cnt_q;
  assign first_err_idx_o = fe_idx_q;
  assign first_err_got_o = fe_got_q;

endmodule
`default_nettype wire
